// File: rtl/pipe_rca_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_adder_pkg
//  Brief    : Shared constants and configuration helpers for pipe_rca_adder.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_adder_pkg;

    localparam int c_DEF_WIDTH  = 16;
    localparam int c_DEF_STAGES = 4;

    // Bits resolved per pipeline stage.
    function automatic int chunk_w(input int width, input int stages);
        return (stages >= 1) ? (width / stages) : width;
    endfunction

    // Legal configuration: at least one stage, no more stages than bits, even split.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_rca_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_rca_adder_if
//  Brief    : Operand/result valid-ready bundle for the pipelined adder.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_rca_adder_if #(
    parameter int WIDTH = pipe_adder_pkg::c_DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/pipe_rca_adder_slice.sv
`default_nettype none
// ============================================================================
//  Module   : rca_slice
//  Brief    : Combinational W-bit ripple of gate-level full adders.
//  Revision : 1.0 - initial release
// ============================================================================
module rca_slice #(
    parameter int W = 4
) (
    input  wire logic [W-1:0] x,
    input  wire logic [W-1:0] y,
    input  wire logic         ci,
    output logic      [W-1:0] s,
    output logic              co,
    output logic              c_msb_in
);
    logic [W:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        logic w_p;
        assign w_p      = x[i] ^ y[i];
        assign s[i]     = w_p ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_p & w_c[i]);
    end

    assign co       = w_c[W];
    // Carry into the top bit is kept so the last stage can derive signed overflow.
    assign c_msb_in = w_c[W-1];

endmodule
`default_nettype wire

// File: rtl/pipe_rca_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_rca_adder
//  Brief    : Pipelined ripple-carry adder/subtractor, one carry chunk per stage.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_rca_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = c_DEF_WIDTH,
    parameter int STAGES = c_DEF_STAGES
) (
    input wire logic        clk,
    input wire logic        rst_n,
    pipe_rca_adder_if.slave bus
);
    localparam int c_CHUNK = chunk_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipe_rca_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    // Row k holds the beat leaving stage k: pending operand chunks and finished sum chunks.
    logic [STAGES-1:0]  r_vld;
    logic               r_cy  [STAGES];
    logic               r_cm  [STAGES];
    logic [c_CHUNK-1:0] r_pa  [STAGES][STAGES];
    logic [c_CHUNK-1:0] r_pb  [STAGES][STAGES];
    logic [c_CHUNK-1:0] r_sum [STAGES][STAGES];

    logic [c_CHUNK-1:0] w_x  [STAGES];
    logic [c_CHUNK-1:0] w_y  [STAGES];
    logic [c_CHUNK-1:0] w_s  [STAGES];
    logic               w_ci [STAGES];
    logic               w_co [STAGES];
    logic               w_cm [STAGES];
    logic [WIDTH-1:0]   w_bp;
    logic [WIDTH-1:0]   w_sum;
    logic               w_adv;

    assign w_bp         = bus.sub ? ~bus.b : bus.b;
    assign w_adv        = !r_vld[STAGES-1] || bus.out_ready;
    assign bus.in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_x[k]  = bus.a[c_CHUNK-1:0];
            assign w_y[k]  = w_bp[c_CHUNK-1:0];
            // Subtraction forces the carry-in high, completing the two's complement of b.
            assign w_ci[k] = bus.sub | bus.cin;
        end else begin : g_next
            assign w_x[k]  = r_pa[k-1][k];
            assign w_y[k]  = r_pb[k-1][k];
            assign w_ci[k] = r_cy[k-1];
        end

        rca_slice #(
            .W (c_CHUNK)
        ) u_slice (
            .x        (w_x[k]),
            .y        (w_y[k]),
            .ci       (w_ci[k]),
            .s        (w_s[k]),
            .co       (w_co[k]),
            .c_msb_in (w_cm[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_cy[k] <= 1'b0;
                r_cm[k] <= 1'b0;
                for (int j = 0; j < STAGES; j++) begin
                    r_pa[k][j]  <= '0;
                    r_pb[k][j]  <= '0;
                    r_sum[k][j] <= '0;
                end
            end
        end else if (w_adv) begin
            r_vld[0] <= bus.in_valid;
            r_cy[0]  <= w_co[0];
            r_cm[0]  <= w_cm[0];
            for (int j = 0; j < STAGES; j++) begin
                r_pa[0][j]  <= bus.a[j*c_CHUNK +: c_CHUNK];
                r_pb[0][j]  <= w_bp[j*c_CHUNK +: c_CHUNK];
                r_sum[0][j] <= (j == 0) ? w_s[0] : '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_cy[k]  <= w_co[k];
                r_cm[k]  <= w_cm[k];
                for (int j = 0; j < STAGES; j++) begin
                    r_pa[k][j]  <= r_pa[k-1][j];
                    r_pb[k][j]  <= r_pb[k-1][j];
                    r_sum[k][j] <= (j == k) ? w_s[k] : r_sum[k-1][j];
                end
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < STAGES; j++) begin
            w_sum[j*c_CHUNK +: c_CHUNK] = r_sum[STAGES-1][j];
        end
    end

    assign bus.out_valid = r_vld[STAGES-1];
    assign bus.sum       = w_sum;
    assign bus.cout      = r_cy[STAGES-1];
    assign bus.ovf       = r_cm[STAGES-1] ^ r_cy[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_pipe_rca_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_rca_adder
//  Brief    : Directed-vector bench for pipe_rca_adder at STAGES = 4, 1 and 16.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_rca_adder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_vec = 0;
    int          n_err = 0;
    logic [17:0] q4[$];
    logic [17:0] q1[$];
    logic [17:0] q16[$];
    logic        p_stall;
    logic [17:0] p_val;
    vec_t        tbl [10];

    always #5 clk = ~clk;

    pipe_rca_adder_if #(.WIDTH(16)) if4  ();
    pipe_rca_adder_if #(.WIDTH(16)) if1  ();
    pipe_rca_adder_if #(.WIDTH(16)) if16 ();

    pipe_rca_adder #(.WIDTH(16), .STAGES(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    pipe_rca_adder #(.WIDTH(16), .STAGES(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    pipe_rca_adder #(.WIDTH(16), .STAGES(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    // The shallow and deep variants see every beat offered to the main instance.
    assign if1.in_valid   = if4.in_valid;
    assign if1.a          = if4.a;
    assign if1.b          = if4.b;
    assign if1.cin        = if4.cin;
    assign if1.sub        = if4.sub;
    assign if1.out_ready  = 1'b1;
    assign if16.in_valid  = if4.in_valid;
    assign if16.a         = if4.a;
    assign if16.b         = if4.b;
    assign if16.cin       = if4.cin;
    assign if16.sub       = if4.sub;
    assign if16.out_ready = 1'b1;

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bp;
        logic [16:0] t;
        logic        ov;
        bp = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, bp} + {16'd0, (sub ? 1'b1 : cin)};
        ov = (a[15] == bp[15]) && (t[15] != a[15]);
        return {ov, t[16], t[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vcin,
                        input logic vsub, input logic [17:0] exp);
        bit ok;
        ok           = 1'b0;
        if4.a        = va;
        if4.b        = vb;
        if4.cin      = vcin;
        if4.sub      = vsub;
        if4.in_valid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (if4.in_ready) begin
                q4.push_back(exp);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboards pop on every output transfer; a stalled output must not change.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_stall = 1'b0;
            end else begin
                if (p_stall)
                    chk("stall_hold", {13'd0, if4.out_valid, if4.ovf, if4.cout, if4.sum},
                        {13'd0, 1'b1, p_val});
                p_stall = if4.out_valid && !if4.out_ready;
                p_val   = {if4.ovf, if4.cout, if4.sum};
                if (if4.out_valid && if4.out_ready) begin
                    if (q4.size() == 0) chk("s4_unexpected_beat", 32'd1, 32'd0);
                    else chk("s4_result", {14'd0, if4.ovf, if4.cout, if4.sum}, {14'd0, q4.pop_front()});
                end
                if (if1.out_valid) begin
                    if (q1.size() == 0) chk("s1_unexpected_beat", 32'd1, 32'd0);
                    else chk("s1_result", {14'd0, if1.ovf, if1.cout, if1.sum}, {14'd0, q1.pop_front()});
                end
                if (if1.in_valid && if1.in_ready)
                    q1.push_back(model(if1.a, if1.b, if1.cin, if1.sub));
                if (if16.out_valid) begin
                    if (q16.size() == 0) chk("s16_unexpected_beat", 32'd1, 32'd0);
                    else chk("s16_result", {14'd0, if16.ovf, if16.cout, if16.sum}, {14'd0, q16.pop_front()});
                end
                if (if16.in_valid && if16.in_ready)
                    q16.push_back(model(if16.a, if16.b, if16.cin, if16.sub));
            end
        end
    endtask

    initial begin : main
        int          lat;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rs;

        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
        tbl[8] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[9] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0};

        rst_n         = 1'b0;
        p_stall       = 1'b0;
        p_val         = '0;
        if4.in_valid  = 1'b0;
        if4.a         = '0;
        if4.b         = '0;
        if4.cin       = 1'b0;
        if4.sub       = 1'b0;
        if4.out_ready = 1'b0;

        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(if4.out_valid), 32'd0);
        chk("rst_sum", 32'(if4.sum), 32'd0);
        chk("rst_flags", 32'({if4.cout, if4.ovf}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 32'(if4.in_ready), 32'd1);
        if4.out_ready = 1'b1;

        // Isolated beats: result via scoreboard, latency measured here.
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, {tbl[i].ovf, tbl[i].cout, tbl[i].sum});
            if4.in_valid = 1'b0;
            lat = 1;
            while (!if4.out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk("latency", 32'(lat), 32'd4);
            @(posedge clk);
            #1;
        end

        // Back-to-back beats against a 1010 output-ready pattern.
        if4.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, {tbl[i].ovf, tbl[i].cout, tbl[i].sum});
                if4.in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk);
                    #1;
                    if4.out_ready = ~if4.out_ready;
                end
            end
        join
        if4.out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_drained", 32'(q4.size()), 32'd0);

        // Three beats in flight, output stalled, then asynchronous reset.
        if4.out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, {tbl[i].ovf, tbl[i].cout, tbl[i].sum});
        if4.in_valid = 1'b0;
        lat = 0;
        while (!if4.out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("filled_before_rst", 32'(if4.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(if4.out_valid), 32'd0);
        chk("async_rst_data", 32'({if4.ovf, if4.cout, if4.sum}), 32'd0);
        q4.delete();
        q1.delete();
        q16.delete();
        if4.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("no_stale_beat", 32'(if4.out_valid), 32'd0);
        end

        // Random beats, streamed; every instance is checked against the model.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        if4.in_valid = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        chk("s4_drained", 32'(q4.size()), 32'd0);
        chk("s1_drained", 32'(q1.size()), 32'd0);
        chk("s16_drained", 32'(q16.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
